// File: rtl/ub_tile_reader_if.sv
// Unified-buffer read port plus mmu activation stream for the tile reader.
// slave = the tile reader itself, master = whatever drives it (sequencer, memory, mmu).
interface ub_tile_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [DATA_W-1:0] a_in1;
  logic [DATA_W-1:0] a_in2;
  logic              a_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, rd_data, out_ready,
    input  rd_en, rd_addr, a_in1, a_in2, a_valid, busy, done
  );

  modport slave (
    input  start, base_addr, rd_data, out_ready,
    output rd_en, rd_addr, a_in1, a_in2, a_valid, busy, done
  );
endinterface

// File: rtl/ub_tile_reader.sv
// Fetches a 2 x N_VEC activation tile from the unified buffer into a local
// buffer, then streams it to the 2x2 mmu with row 1 skewed one beat behind row 0.
module ub_tile_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int N_VEC  = 2
) (
  input logic              clk,
  input logic              reset,
  ub_tile_reader_if.slave  bus
);

  localparam int C_W = (N_VEC > 1) ? $clog2(N_VEC) : 1;
  localparam int T_W = $clog2(N_VEC + 1);
  localparam logic [C_W-1:0] LAST_COL  = C_W'(N_VEC - 1);
  localparam logic [T_W-1:0] LAST_BEAT = T_W'(N_VEC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_STREAM, S_DONE
  } state_t;

  state_t            state;
  logic              f_row;      // row of the read currently on rd_addr
  logic [C_W-1:0]    f_col;
  logic              p_vld;      // a read was issued last cycle; rd_data is live
  logic              p_row;
  logic [C_W-1:0]    p_col;
  logic [T_W-1:0]    t;
  logic [T_W-1:0]    t_nxt;
  logic [1:0][N_VEC-1:0][DATA_W-1:0] tile_buf;

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] a_in1_q;
  logic [DATA_W-1:0] a_in2_q;
  logic              a_valid_q;
  logic              busy_q;
  logic              done_q;

  // Upper bits of each buffer word are dropped (plain truncation).
  logic unused_rd_hi;
  assign unused_rd_hi = ^bus.rd_data[31:DATA_W];

  assign t_nxt       = t + 1'b1;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.a_in1   = a_in1_q;
  assign bus.a_in2   = a_in2_q;
  assign bus.a_valid = a_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  // Capture read data one cycle after each issued read into its tile slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_vld    <= 1'b0;
      p_row    <= 1'b0;
      p_col    <= '0;
      tile_buf <= '0;
    end else begin
      p_vld <= rd_en_q;
      p_row <= f_row;
      p_col <= f_col;
      if (p_vld) tile_buf[p_row][p_col] <= bus.rd_data[DATA_W-1:0];
    end
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      f_row     <= 1'b0;
      f_col     <= '0;
      t         <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      a_in1_q   <= '0;
      a_in2_q   <= '0;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state     <= S_FETCH;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= bus.base_addr;
            f_row     <= 1'b0;
            f_col     <= '0;
          end
        end
        S_FETCH: begin
          if (f_row && f_col == LAST_COL) begin
            rd_en_q <= 1'b0;
            state   <= S_DRAIN;
          end else begin
            // Address wraps naturally at ADDR_W bits.
            rd_addr_q <= rd_addr_q + 1'b1;
            if (f_col == LAST_COL) begin
              f_col <= '0;
              f_row <= 1'b1;
            end else begin
              f_col <= f_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Row 0 is already captured; beat 0 only needs a[0][0].
          state     <= S_STREAM;
          t         <= '0;
          a_valid_q <= 1'b1;
          a_in1_q   <= tile_buf[1'b0][0];
          a_in2_q   <= '0;
        end
        S_STREAM: begin
          if (bus.out_ready) begin
            if (t == LAST_BEAT) begin
              a_valid_q <= 1'b0;
              a_in1_q   <= '0;
              a_in2_q   <= '0;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end else begin
              t       <= t_nxt;
              a_in1_q <= (t_nxt < LAST_BEAT) ? tile_buf[1'b0][t_nxt[C_W-1:0]] : '0;
              a_in2_q <= tile_buf[1'b1][t[C_W-1:0]];
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ub_tile_reader.sv
// Bench for ub_tile_reader: memory model, scoreboard of read addresses and
// accepted beats, plus per-scenario timing checks.
module tb_ub_tile_reader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int N_VEC  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ub_tile_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  ub_tile_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_VEC(N_VEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];

  // Unified buffer model: one-cycle read latency, junk when idle.
  always @(posedge clk) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : $urandom;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_beat[$];
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_beat;

  // Scoreboard: every issued read and every accepted beat is popped and compared.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_en) begin
        total++;
        if (exp_addr.size() == 0) begin
          bad++;
          $display("FAIL rd_addr: unexpected read of %0d, expected none", bus.rd_addr);
        end else begin
          m_addr = exp_addr.pop_front();
          if (bus.rd_addr !== m_addr) begin
            bad++;
            $display("FAIL rd_addr: got %0d expected %0d", bus.rd_addr, m_addr);
          end
        end
      end
      if (bus.a_valid && bus.out_ready) begin
        total++;
        if (exp_beat.size() == 0) begin
          bad++;
          $display("FAIL beat: unexpected beat %h/%h, expected none", bus.a_in1, bus.a_in2);
        end else begin
          m_beat = exp_beat.pop_front();
          if ({bus.a_in1, bus.a_in2} !== m_beat) begin
            bad++;
            $display("FAIL beat: got %h/%h expected %h/%h", bus.a_in1, bus.a_in2,
                     m_beat[31:16], m_beat[15:0]);
          end
        end
      end
    end
  end

  // Per-cycle observations from the last observe() run, indexed by cycle after start.
  logic [DATA_W-1:0] s_a1 [0:63];
  logic [DATA_W-1:0] s_a2 [0:63];
  logic              s_v  [0:63];
  int first_v, done_c, done_n, busy_n, idle_c;

  // Runs ncyc cycles after a start edge, stalling out_ready in [slo,shi] and
  // pulsing start (base 40) on cycles s1/s2. Measures only, no checking.
  task automatic observe(input int ncyc, input int slo, input int shi,
                         input int s1, input int s2);
    first_v = -1; done_c = -1; done_n = 0; busy_n = 0; idle_c = -1;
    for (int c = 1; c <= ncyc; c++) begin
      bus.out_ready = !(c >= slo && c <= shi);
      if (c == s1 || c == s2) begin
        bus.start = 1'b1; bus.base_addr = 6'd40;
      end else begin
        bus.start = 1'b0; bus.base_addr = 6'($urandom);
      end
      @(negedge clk);
      s_a1[c] = bus.a_in1; s_a2[c] = bus.a_in2; s_v[c] = bus.a_valid;
      if (bus.a_valid && first_v < 0) first_v = c;
      if (bus.done) begin done_n++; if (done_c < 0) done_c = c; end
      if (bus.busy) busy_n++;
      else if (idle_c < 0) idle_c = c;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    bus.base_addr = base;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_tile(input logic [ADDR_W-1:0] base);
    logic [31:0] a1, a2;
    for (int i = 0; i < 2 * N_VEC; i++) exp_addr.push_back(ADDR_W'(base + i));
    for (int t = 0; t <= N_VEC; t++) begin
      a1 = (t < N_VEC) ? mem[ADDR_W'(base + t)] : 32'd0;
      a2 = (t >= 1) ? mem[ADDR_W'(base + N_VEC + t - 1)] : 32'd0;
      exp_beat.push_back({a1[15:0], a2[15:0]});
    end
  endtask

  task automatic push_basic();
    exp_addr.push_back(6'd10); exp_addr.push_back(6'd11);
    exp_addr.push_back(6'd12); exp_addr.push_back(6'd13);
    exp_beat.push_back({16'd11, 16'd0});
    exp_beat.push_back({16'd12, 16'd21});
    exp_beat.push_back({16'd0,  16'd22});
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base_addr = '0; bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.rd_en, bus.rd_addr, bus.a_in1, bus.a_in2, bus.a_valid, bus.busy, bus.done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.rd_en, bus.rd_addr, bus.a_in1, bus.a_in2, bus.a_valid, bus.busy, bus.done});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    mem[10] = 32'd11; mem[11] = 32'd12; mem[12] = 32'd21; mem[13] = 32'd22;
    push_basic();
    do_start(6'd10);
    observe(12, 99, 0, -1, -1);
    total++;
    if (first_v !== 6) begin bad++; $display("FAIL basic_latency: first valid %0d expected 6", first_v); end
    total++;
    if (done_c !== 9 || done_n !== 1) begin
      bad++; $display("FAIL basic_done: cycle %0d count %0d expected 9/1", done_c, done_n);
    end
    total++;
    if (busy_n !== 9 || idle_c !== 10) begin
      bad++; $display("FAIL basic_busy: cycles %0d idle at %0d expected 9/10", busy_n, idle_c);
    end
    total++;
    if ({s_v[9], s_a1[9], s_a2[9]} !== '0) begin
      bad++; $display("FAIL basic_after: v=%b a1=%h a2=%h expected 0", s_v[9], s_a1[9], s_a2[9]);
    end
    total++;
    if (exp_addr.size() != 0 || exp_beat.size() != 0) begin
      bad++; $display("FAIL basic_drain: left %0d addr %0d beats expected 0", exp_addr.size(), exp_beat.size());
    end
  endtask

  task automatic test_backpressure();
    push_basic();
    do_start(6'd10);
    observe(14, 7, 8, -1, -1);
    for (int c = 7; c <= 9; c++) begin
      total++;
      if (s_v[c] !== 1'b1 || s_a1[c] !== 16'd12 || s_a2[c] !== 16'd21) begin
        bad++;
        $display("FAIL bp_hold c%0d: v=%b a1=%0d a2=%0d expected 1/12/21", c, s_v[c], s_a1[c], s_a2[c]);
      end
    end
    total++;
    if (done_c !== 11 || idle_c !== 12) begin
      bad++; $display("FAIL bp_done: done %0d idle %0d expected 11/12", done_c, idle_c);
    end
    total++;
    if (exp_beat.size() != 0) begin bad++; $display("FAIL bp_drain: %0d beats left expected 0", exp_beat.size()); end
  endtask

  task automatic test_wrap();
    mem[62] = 32'd5; mem[63] = 32'd6; mem[0] = 32'd7; mem[1] = 32'd8;
    exp_addr.push_back(6'd62); exp_addr.push_back(6'd63);
    exp_addr.push_back(6'd0);  exp_addr.push_back(6'd1);
    exp_beat.push_back({16'd5, 16'd0});
    exp_beat.push_back({16'd6, 16'd7});
    exp_beat.push_back({16'd0, 16'd8});
    do_start(6'd62);
    observe(12, 99, 0, -1, -1);
    total++;
    if (done_c !== 9 || exp_addr.size() != 0 || exp_beat.size() != 0) begin
      bad++; $display("FAIL wrap_done: done %0d left %0d/%0d expected 9/0/0", done_c, exp_addr.size(), exp_beat.size());
    end
  endtask

  task automatic test_truncation();
    mem[20] = 32'h0001_ABCD; mem[21] = 32'hFFFF_0001;
    mem[22] = 32'h1234_5678; mem[23] = 32'h8000_FFFF;
    for (int i = 20; i < 24; i++) exp_addr.push_back(ADDR_W'(i));
    exp_beat.push_back({16'hABCD, 16'h0000});
    exp_beat.push_back({16'h0001, 16'h5678});
    exp_beat.push_back({16'h0000, 16'hFFFF});
    do_start(6'd20);
    observe(12, 99, 0, -1, -1);
    total++;
    if (s_a1[6] !== 16'hABCD) begin bad++; $display("FAIL trunc_beat0: got %h expected abcd", s_a1[6]); end
  endtask

  task automatic test_ignored_start();
    for (int i = 40; i < 44; i++) mem[i] = $urandom;
    push_tile(6'd10);
    do_start(6'd10);
    observe(9, 99, 0, 7, 9);
    total++;
    if (done_n !== 1 || exp_addr.size() != 0) begin
      bad++; $display("FAIL ign_first: done %0d addr left %0d expected 1/0", done_n, exp_addr.size());
    end
    push_tile(6'd40);
    do_start(6'd40);
    observe(12, 99, 0, -1, -1);
    total++;
    if (first_v !== 6 || done_c !== 9) begin
      bad++; $display("FAIL ign_second: first %0d done %0d expected 6/9", first_v, done_c);
    end
    total++;
    if (exp_addr.size() != 0 || exp_beat.size() != 0) begin
      bad++; $display("FAIL ign_drain: left %0d/%0d expected 0/0", exp_addr.size(), exp_beat.size());
    end
  endtask

  task automatic test_reset_mid();
    push_basic();
    do_start(6'd10);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.rd_en, bus.rd_addr, bus.a_in1, bus.a_in2, bus.a_valid, bus.busy, bus.done} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {bus.rd_en, bus.rd_addr, bus.a_in1, bus.a_in2, bus.a_valid, bus.busy, bus.done});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL midreset_quiet: done=%b busy=%b expected 0/0", bus.done, bus.busy);
      end
    end
    exp_addr.delete();
    exp_beat.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    push_basic();
    do_start(6'd10);
    observe(12, 99, 0, -1, -1);
    total++;
    if (first_v !== 6 || done_c !== 9 || done_n !== 1) begin
      bad++; $display("FAIL midreset_rerun: first %0d done %0d n %0d expected 6/9/1", first_v, done_c, done_n);
    end
    total++;
    if (exp_addr.size() != 0 || exp_beat.size() != 0) begin
      bad++; $display("FAIL midreset_drain: left %0d/%0d expected 0/0", exp_addr.size(), exp_beat.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_truncation();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
